// File: rtl/eth_uart_top.sv
// FPGA top: UART byte echo plus RMII port-1 frame byte counter, all on clk_200_mhz.
// Echo starts one cycle after a byte is received; one newest byte is held while an echo is in flight.
`timescale 1ns/1ps
module eth_uart_top #(
    parameter int CLKS_PER_BIT = 1736,
    parameter int RMII_DIV     = 4
) (
    input  logic       clk_200_mhz,
    input  logic       rst,
    input  logic       uart_rx,
    output logic       uart_tx,
    input  logic       crs_dv_1,
    input  logic [1:0] rx_d_1,
    input  logic       rx_er_1,
    output logic [1:0] tx_d_1,
    output logic       tx_e_1,
    output logic       clk_50_mhz_1,
    output logic       rst_n_1,
    output logic       mdc_1,
    inout  wire        mdio_1,
    input  logic       crs_dv_2,
    input  logic [1:0] rx_d_2,
    input  logic       rx_er_2,
    output logic [1:0] tx_d_2,
    output logic       tx_e_2,
    output logic       clk_50_mhz_2,
    output logic       rst_n_2,
    output logic       mdc_2,
    inout  wire        mdio_2,
    input  logic       btn,
    output logic [7:0] led
);
    localparam int DW = (RMII_DIV > 2) ? $clog2(RMII_DIV) : 1;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [DW-1:0] DIV_LAST  = DW'(RMII_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF  = DW'(RMII_DIV / 2);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {ETH_IDLE, ETH_PRE, ETH_DATA} eth_state_t;

    logic [DW-1:0] r_div;
    logic          r_phy_rst_n;
    logic          w_strobe;

    always_ff @(posedge clk_200_mhz) begin
        if (rst) begin
            r_div       <= '0;
            r_phy_rst_n <= 1'b0;
        end else begin
            r_div       <= (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
            r_phy_rst_n <= 1'b1;
        end
    end

    assign w_strobe     = (r_div == DIV_LAST);
    assign clk_50_mhz_1 = (r_div >= DIV_HALF);
    assign clk_50_mhz_2 = clk_50_mhz_1;
    assign rst_n_1      = r_phy_rst_n;
    assign rst_n_2      = r_phy_rst_n;
    assign tx_d_1       = 2'b00;
    assign tx_d_2       = 2'b00;
    assign tx_e_1       = 1'b0;
    assign tx_e_2       = 1'b0;
    assign mdc_1        = 1'b0;
    assign mdc_2        = 1'b0;
    assign mdio_1       = 1'bz;
    assign mdio_2       = 1'bz;

    // UART receiver
    rx_state_t     r_rx_state, w_rx_state_nxt;
    logic          r_rx_s1, r_rx_s2;
    logic [CW-1:0] r_rx_cnt, w_rx_cnt_nxt;
    logic [2:0]    r_rx_bit, w_rx_bit_nxt;
    logic [7:0]    r_rx_shift, w_rx_shift_nxt;
    logic          w_rx_done;
    logic          r_rx_vld;
    logic [7:0]    r_uart_last;

    always_ff @(posedge clk_200_mhz) begin
        if (rst) begin
            r_rx_s1     <= 1'b1;
            r_rx_s2     <= 1'b1;
            r_rx_state  <= RX_IDLE;
            r_rx_cnt    <= '0;
            r_rx_bit    <= '0;
            r_rx_shift  <= '0;
            r_rx_vld    <= 1'b0;
            r_uart_last <= '0;
        end else begin
            r_rx_s1    <= uart_rx;
            r_rx_s2    <= r_rx_s1;
            r_rx_state <= w_rx_state_nxt;
            r_rx_cnt   <= w_rx_cnt_nxt;
            r_rx_bit   <= w_rx_bit_nxt;
            r_rx_shift <= w_rx_shift_nxt;
            r_rx_vld   <= w_rx_done;
            if (w_rx_done)
                r_uart_last <= r_rx_shift;
        end
    end

    always_comb begin
        w_rx_state_nxt = r_rx_state;
        w_rx_cnt_nxt   = r_rx_cnt + 1'b1;
        w_rx_bit_nxt   = r_rx_bit;
        w_rx_shift_nxt = r_rx_shift;
        w_rx_done      = 1'b0;
        case (r_rx_state)
            RX_IDLE: begin
                w_rx_cnt_nxt = '0;
                if (!r_rx_s2)
                    w_rx_state_nxt = RX_START;
            end
            RX_START: begin
                // A low that does not survive to mid-bit is treated as a glitch.
                if (r_rx_cnt == HALF_LAST) begin
                    w_rx_cnt_nxt   = '0;
                    w_rx_bit_nxt   = '0;
                    w_rx_state_nxt = r_rx_s2 ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (r_rx_cnt == BIT_LAST) begin
                    w_rx_cnt_nxt   = '0;
                    w_rx_shift_nxt = {r_rx_shift[6:0], r_rx_s2};
                    w_rx_bit_nxt   = r_rx_bit + 1'b1;
                    if (r_rx_bit == 3'd7)
                        w_rx_state_nxt = RX_STOP;
                end
            end
            RX_STOP: begin
                if (r_rx_cnt == BIT_LAST) begin
                    w_rx_cnt_nxt   = '0;
                    w_rx_done      = r_rx_s2;
                    w_rx_state_nxt = RX_IDLE;
                end
            end
            default: w_rx_state_nxt = RX_IDLE;
        endcase
    end

    // UART echo transmitter with a single overwrite-on-arrival pending slot
    logic          r_tx_busy;
    logic [9:0]    r_tx_shift;
    logic [CW-1:0] r_tx_cnt;
    logic [3:0]    r_tx_bits;
    logic          r_uart_tx;
    logic          r_pend_vld;
    logic [7:0]    r_pend_dat;
    logic          w_tx_start;
    logic [7:0]    w_tx_byte;

    assign w_tx_start = !r_tx_busy && (r_pend_vld || r_rx_vld);
    assign w_tx_byte  = r_pend_vld ? r_pend_dat : r_uart_last;

    always_ff @(posedge clk_200_mhz) begin
        if (rst) begin
            r_tx_busy  <= 1'b0;
            r_tx_shift <= '1;
            r_tx_cnt   <= '0;
            r_tx_bits  <= '0;
            r_uart_tx  <= 1'b1;
            r_pend_vld <= 1'b0;
            r_pend_dat <= '0;
        end else begin
            if (r_rx_vld && !(w_tx_start && !r_pend_vld)) begin
                r_pend_vld <= 1'b1;
                r_pend_dat <= r_uart_last;
            end else if (w_tx_start) begin
                r_pend_vld <= 1'b0;
            end

            if (w_tx_start) begin
                r_tx_busy  <= 1'b1;
                r_tx_shift <= {1'b0, w_tx_byte, 1'b1};
                r_tx_cnt   <= '0;
                r_tx_bits  <= '0;
                r_uart_tx  <= 1'b0;
            end else if (r_tx_busy) begin
                if (r_tx_cnt == BIT_LAST) begin
                    r_tx_cnt <= '0;
                    if (r_tx_bits == 4'd9) begin
                        r_tx_busy <= 1'b0;
                    end else begin
                        r_uart_tx  <= r_tx_shift[8];
                        r_tx_shift <= {r_tx_shift[8:0], 1'b1};
                        r_tx_bits  <= r_tx_bits + 1'b1;
                    end
                end else begin
                    r_tx_cnt <= r_tx_cnt + 1'b1;
                end
            end
        end
    end

    assign uart_tx = r_uart_tx;

    // RMII port-1 receiver: counts whole bytes between SFD and carrier drop
    eth_state_t  r_eth_state, w_eth_state_nxt;
    logic [1:0]  r_dib_cnt, w_dib_nxt;
    logic [15:0] r_byte_cnt, w_byte_nxt;
    logic        r_bad, w_bad_nxt;
    logic [15:0] r_eth_cnt, w_eth_cnt_nxt;

    always_ff @(posedge clk_200_mhz) begin
        if (rst) begin
            r_eth_state <= ETH_IDLE;
            r_dib_cnt   <= '0;
            r_byte_cnt  <= '0;
            r_bad       <= 1'b0;
            r_eth_cnt   <= '0;
        end else begin
            r_eth_state <= w_eth_state_nxt;
            r_dib_cnt   <= w_dib_nxt;
            r_byte_cnt  <= w_byte_nxt;
            r_bad       <= w_bad_nxt;
            r_eth_cnt   <= w_eth_cnt_nxt;
        end
    end

    always_comb begin
        w_eth_state_nxt = r_eth_state;
        w_dib_nxt       = r_dib_cnt;
        w_byte_nxt      = r_byte_cnt;
        w_bad_nxt       = r_bad;
        w_eth_cnt_nxt   = r_eth_cnt;
        if (w_strobe) begin
            case (r_eth_state)
                ETH_IDLE: begin
                    if (crs_dv_1 && rx_d_1 == 2'b01)
                        w_eth_state_nxt = ETH_PRE;
                end
                ETH_PRE: begin
                    if (!crs_dv_1 || (rx_d_1 != 2'b01 && rx_d_1 != 2'b11)) begin
                        w_eth_state_nxt = ETH_IDLE;
                    end else if (rx_d_1 == 2'b11) begin
                        w_eth_state_nxt = ETH_DATA;
                        w_dib_nxt       = '0;
                        w_byte_nxt      = '0;
                        w_bad_nxt       = 1'b0;
                    end
                end
                ETH_DATA: begin
                    w_bad_nxt = r_bad | rx_er_1;
                    if (!crs_dv_1) begin
                        w_eth_state_nxt = ETH_IDLE;
                        if (!w_bad_nxt)
                            w_eth_cnt_nxt = r_byte_cnt;
                    end else begin
                        w_dib_nxt = r_dib_cnt + 1'b1;
                        if (r_dib_cnt == 2'd3 && r_byte_cnt != 16'hFFFF)
                            w_byte_nxt = r_byte_cnt + 1'b1;
                    end
                end
                default: w_eth_state_nxt = ETH_IDLE;
            endcase
        end
    end

    logic w_unused;
    assign w_unused = ^{crs_dv_2, rx_d_2, rx_er_2, r_eth_cnt[15:8]};

    assign led = btn ? r_eth_cnt[7:0] : r_uart_last;

endmodule

// File: tb/tb_eth_uart_top.sv
// Bench for eth_uart_top: UART echo scoreboard plus RMII frame-count checks on the LEDs.
`timescale 1ns/1ps
module tb_eth_uart_top;
    localparam int CPB = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       uart_rx = 1'b1;
    logic       uart_tx;
    logic       crs_dv_1 = 1'b0, rx_er_1 = 1'b0;
    logic [1:0] rx_d_1 = 2'b00;
    logic       crs_dv_2 = 1'b0, rx_er_2 = 1'b0;
    logic [1:0] rx_d_2 = 2'b00;
    logic [1:0] tx_d_1, tx_d_2;
    logic       tx_e_1, tx_e_2, clk_50_mhz_1, clk_50_mhz_2, rst_n_1, rst_n_2, mdc_1, mdc_2;
    wire        mdio_1, mdio_2;
    logic       btn = 1'b0;
    logic [7:0] led;

    always #2.5 clk = ~clk;

    eth_uart_top #(.CLKS_PER_BIT(CPB), .RMII_DIV(4)) dut (
        .clk_200_mhz(clk), .rst(rst), .uart_rx(uart_rx), .uart_tx(uart_tx),
        .crs_dv_1(crs_dv_1), .rx_d_1(rx_d_1), .rx_er_1(rx_er_1), .tx_d_1(tx_d_1), .tx_e_1(tx_e_1),
        .clk_50_mhz_1(clk_50_mhz_1), .rst_n_1(rst_n_1), .mdc_1(mdc_1), .mdio_1(mdio_1),
        .crs_dv_2(crs_dv_2), .rx_d_2(rx_d_2), .rx_er_2(rx_er_2), .tx_d_2(tx_d_2), .tx_e_2(tx_e_2),
        .clk_50_mhz_2(clk_50_mhz_2), .rst_n_2(rst_n_2), .mdc_2(mdc_2), .mdio_2(mdio_2),
        .btn(btn), .led(led)
    );

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] echo_q[$];
    logic [7:0] m_uart = 8'h00;
    logic [7:0] m_eth  = 8'h00;
    logic       mon_busy = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Echo monitor: decode MSB-first frames on uart_tx and pop the scoreboard.
    initial begin
        logic [7:0] b;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (uart_tx === 1'b0) begin
                mon_busy = 1'b1;
                repeat (CPB / 2) @(negedge clk);
                check_val("echo_start", {31'b0, uart_tx}, 0);
                b = 8'h00;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b = {b[6:0], uart_tx};
                end
                repeat (CPB) @(negedge clk);
                check_val("echo_stop", {31'b0, uart_tx}, 1);
                check_val("echo_expected", {31'b0, echo_q.size() != 0}, 1);
                if (echo_q.size() != 0) begin
                    e = echo_q.pop_front();
                    check_val("echo_byte", {24'b0, b}, {24'b0, e});
                end
                mon_busy = 1'b0;
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic send_uart(input logic [7:0] b);
        echo_q.push_back(b);
        m_uart = b;
        @(negedge clk) uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 7; i >= 0; i--) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = 1'b1;
        repeat (CPB) @(negedge clk);
        btn = 1'b0;
        @(negedge clk);
        check_val("led_uart", {24'b0, led}, {24'b0, m_uart});
    endtask

    task automatic drain_echo();
        for (int i = 0; i < 40 * CPB; i++) begin
            if (echo_q.size() == 0 && !mon_busy) break;
            @(negedge clk);
        end
        check_val("echo_drain", echo_q.size(), 0);
    endtask

    task automatic ref_edge();
        logic prev;
        prev = clk_50_mhz_1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (!prev && clk_50_mhz_1) return;
            prev = clk_50_mhz_1;
        end
        check_val("ref_clk_timeout", 0, 1);
    endtask

    task automatic dib(input logic crs, input logic [1:0] d, input logic er);
        ref_edge();
        crs_dv_1 = crs;
        rx_d_1   = d;
        rx_er_1  = er;
    endtask

    // err_at: data dibit index carrying rx_er (-1 none); bad_pre: preamble 01,01,10 without SFD.
    task automatic send_frame(input int nbytes, input int err_at, input bit bad_pre);
        logic [7:0] b;
        if (bad_pre) begin
            dib(1, 2'b01, 0); dib(1, 2'b01, 0); dib(1, 2'b10, 0);
        end else begin
            for (int i = 0; i < 7; i++) dib(1, 2'b01, 0);
            dib(1, 2'b11, 0);
        end
        for (int i = 0; i < nbytes; i++) begin
            b = bad_pre ? 8'hAA : (i[7:0] ^ 8'h5A);
            for (int k = 0; k < 4; k++)
                dib(1, b[2*k +: 2], (i * 4 + k) == err_at);
        end
        for (int i = 0; i < 4; i++) dib(1, 2'b00, 0);
        dib(0, 2'b00, 0);
        dib(0, 2'b00, 0);
        dib(0, 2'b00, 0);
        if (!bad_pre && err_at < 0) m_eth = 8'((nbytes + 1) & 255);
        btn = 1'b1;
        @(negedge clk);
        check_val("led_eth", {24'b0, led}, {24'b0, m_eth});
    endtask

    initial begin
        int cyc;
        logic prev;
        repeat (100) @(negedge clk);
        check_val("rst_uart_tx", {31'b0, uart_tx}, 1);
        check_val("rst_led_btn0", {24'b0, led}, 0);
        check_val("rst_n_1_in_reset", {31'b0, rst_n_1}, 0);
        check_val("rst_n_2_in_reset", {31'b0, rst_n_2}, 0);
        btn = 1'b1;
        @(negedge clk);
        check_val("rst_led_btn1", {24'b0, led}, 0);
        btn = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_n_1_after", {31'b0, rst_n_1}, 1);

        ref_edge();
        cyc  = 0;
        prev = clk_50_mhz_1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            cyc++;
            if (!prev && clk_50_mhz_1) break;
            prev = clk_50_mhz_1;
        end
        check_val("clk50_period_ns", cyc * 5, 20);
        check_val("clk50_2_match", {31'b0, clk_50_mhz_2}, {31'b0, clk_50_mhz_1});

        send_uart(8'h08);
        drain_echo();
        send_uart(8'h08);
        send_uart(8'h09);
        drain_echo();
        send_uart(8'hA5);
        drain_echo();

        // Start glitch shorter than half a bit must not produce a byte.
        uart_rx = 1'b0;
        repeat (CPB / 4) @(negedge clk);
        uart_rx = 1'b1;
        repeat (14 * CPB) @(negedge clk);
        check_val("glitch_led", {24'b0, led}, {24'b0, m_uart});
        check_val("glitch_no_echo", {31'b0, mon_busy}, 0);

        send_frame(60, -1, 0);
        send_frame(80, 100, 0);
        send_frame(20, -1, 1);
        send_frame(300, -1, 0);

        btn = 1'b0;
        @(negedge clk);
        check_val("led_btn0_mux", {24'b0, led}, {24'b0, m_uart});
        check_val("tx_d_1_const", {30'b0, tx_d_1}, 0);
        check_val("tx_e_1_const", {31'b0, tx_e_1}, 0);
        check_val("mdc_1_const", {31'b0, mdc_1}, 0);
        check_val("mdio_1_hiz", {31'b0, mdio_1 === 1'bz}, 1);

        rst = 1'b1;
        repeat (5) @(negedge clk);
        check_val("rst2_led_btn0", {24'b0, led}, 0);
        btn = 1'b1;
        @(negedge clk);
        check_val("rst2_led_btn1", {24'b0, led}, 0);
        check_val("rst2_uart_tx", {31'b0, uart_tx}, 1);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
